// File: rtl/srdl_apb_regif_if.sv
// APB3 bus bundle between the SoC fabric (master) and the register-bank completer (slave).
interface srdl_apb_regif_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/srdl_apb_regif.sv
// APB3 completer issuing one-hot rd/wr strobes to a bank of srdlField registers.
// Optional macro SRDL_APB_PSLVERR_EN: flag misaligned/out-of-range transfers with pslverr.
//
// state  | meaning
// IDLE   | waiting for an APB setup phase
// STROBE | one-cycle field strobe; read data captured at its closing edge
// RESP   | pready (and pslverr) presented for one cycle
module srdl_apb_regif #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           rst_l,
  srdl_apb_regif_if.slave                apb,
  output logic [NUM_REGS-1:0]            reg_rd,
  output logic [NUM_REGS-1:0]            reg_wr,
  output logic                           acc,
  output logic [DATA_WIDTH-1:0]          sw_wdata,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_rdata
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {IDLE, STROBE, RESP} state_t;

  state_t                state;
  logic [IW-1:0]         addr_idx;
  logic                  addr_ok;
  logic [NUM_REGS-1:0]   addr_hot;
  logic [IDX_W-1:0]      idx_q;
  logic                  wr_q;
  logic                  ok_q;
  logic [DATA_WIDTH-1:0] rd_sel;
  logic                  setup;

  assign setup    = apb.psel && !apb.penable;
  assign addr_idx = apb.paddr[ADDR_WIDTH-1:2];
  assign addr_ok  = (apb.paddr[1:0] == 2'b00) && (64'(addr_idx) < 64'(NUM_REGS));

  always_comb begin
    addr_hot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      addr_hot[i] = (64'(addr_idx) == 64'(i));
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_q == IDX_W'(i)) rd_sel = reg_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef SRDL_APB_PSLVERR_EN
  logic pslverr_q;
  assign apb.pslverr = pslverr_q;
`else
  assign apb.pslverr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= IDLE;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      ok_q       <= 1'b0;
      reg_rd     <= '0;
      reg_wr     <= '0;
      acc        <= 1'b0;
      sw_wdata   <= '0;
      apb.prdata <= '0;
      apb.pready <= 1'b0;
`ifdef SRDL_APB_PSLVERR_EN
      pslverr_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          apb.pready <= 1'b0;
`ifdef SRDL_APB_PSLVERR_EN
          pslverr_q  <= 1'b0;
`endif
          if (setup) begin
            wr_q  <= apb.pwrite;
            ok_q  <= addr_ok;
            idx_q <= addr_idx[IDX_W-1:0];
            if (addr_ok) begin
              acc <= 1'b1;
              if (apb.pwrite) begin
                reg_wr   <= addr_hot;
                sw_wdata <= apb.pwdata;
              end else begin
                reg_rd <= addr_hot;
              end
            end
            state <= STROBE;
          end
        end
        STROBE: begin
          // The strobe is never retracted, even when the initiator aborts.
          reg_rd <= '0;
          reg_wr <= '0;
          acc    <= 1'b0;
          if (!wr_q) apb.prdata <= ok_q ? rd_sel : '0;
          if (apb.psel) begin
            apb.pready <= 1'b1;
`ifdef SRDL_APB_PSLVERR_EN
            pslverr_q  <= !ok_q;
`endif
            state <= RESP;
          end else begin
            state <= IDLE;
          end
        end
        RESP: begin
          apb.pready <= 1'b0;
`ifdef SRDL_APB_PSLVERR_EN
          pslverr_q  <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_srdl_apb_regif.sv
// Directed bench for srdl_apb_regif with a small field-bank model (register 3 is read-clear).
module tb_srdl_apb_regif;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NR = 16;

  logic clk;
  logic rst_l;
  logic [NR-1:0]    reg_rd;
  logic [NR-1:0]    reg_wr;
  logic             acc;
  logic [DW-1:0]    sw_wdata;
  logic [NR*DW-1:0] reg_rdata;
  logic [DW-1:0]    field [NR];

  int checks;
  int failures;
  int overlap;
  logic exp_err;

  srdl_apb_regif_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  srdl_apb_regif #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .apb       (apb),
    .reg_rd    (reg_rd),
    .reg_wr    (reg_wr),
    .acc       (acc),
    .sw_wdata  (sw_wdata),
    .reg_rdata (reg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NR; i++) field[i] <= (i == 3) ? 32'h5A5A_0001 : 32'h0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (reg_wr[i]) field[i] <= sw_wdata;
        else if (i == 3 && reg_rd[i]) field[i] <= 32'h0;
      end
    end
  end

  always_comb begin
    reg_rdata = '0;
    for (int i = 0; i < NR; i++) reg_rdata[i*DW +: DW] = field[i];
  end

  always @(negedge clk) if ((reg_rd & reg_wr) != '0) overlap++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setup(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = a; apb.pwdata = d;
  endtask

  task automatic access(input logic keep);
    @(posedge clk); #1;
    apb.psel = keep; apb.penable = keep;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle_bus();
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; overlap = 0;
`ifdef SRDL_APB_PSLVERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst_l = 1'b0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
    #3;
    chk("rst_pready", apb.pready, 0);
    chk("rst_pslverr", apb.pslverr, 0);
    chk("rst_prdata", apb.prdata, 0);
    chk("rst_strobes", {reg_rd, reg_wr, acc}, 0);
    @(posedge clk); #1 rst_l = 1'b1;

    // write 0xDEADBEEF to 0x008
    setup(1'b1, 12'h008, 32'hDEAD_BEEF);
    access(1'b1);
    @(negedge clk);
    chk("wr8_t1_reg_wr", reg_wr, 16'h0004);
    chk("wr8_t1_reg_rd", reg_rd, 16'h0000);
    chk("wr8_t1_acc", acc, 1);
    chk("wr8_t1_wdata", sw_wdata, 32'hDEAD_BEEF);
    chk("wr8_t1_pready", apb.pready, 0);
    next_cycle();
    @(negedge clk);
    chk("wr8_t2_pready", apb.pready, 1);
    chk("wr8_t2_pslverr", apb.pslverr, 0);
    chk("wr8_t2_strobe_gone", {reg_wr, acc}, 0);
    chk("wr8_t2_field", field[2], 32'hDEAD_BEEF);

    // read 0x00C, register 3 read-clear
    setup(1'b0, 12'h00C, 32'h0);
    access(1'b1);
    @(negedge clk);
    chk("rd12_t1_reg_rd", reg_rd, 16'h0008);
    chk("rd12_t1_acc", acc, 1);
    next_cycle();
    @(negedge clk);
    chk("rd12_t2_prdata", apb.prdata, 32'h5A5A_0001);
    chk("rd12_t2_pready", apb.pready, 1);
    chk("rd12_field_cleared", field[3], 0);

    // misaligned write 0x006
    setup(1'b1, 12'h006, 32'hFFFF_FFFF);
    access(1'b1);
    @(negedge clk);
    chk("wr6_t1_strobes", {reg_rd, reg_wr, acc}, 0);
    next_cycle();
    @(negedge clk);
    chk("wr6_t2_pready", apb.pready, 1);
    chk("wr6_t2_pslverr", apb.pslverr, exp_err);
    chk("wr6_prdata_held", apb.prdata, 32'h5A5A_0001);
    chk("wr6_field1", field[1], 0);

    // out-of-range read 0x040
    setup(1'b0, 12'h040, 32'h0);
    access(1'b1);
    @(negedge clk);
    chk("rd40_t1_strobes", {reg_rd, reg_wr, acc}, 0);
    next_cycle();
    @(negedge clk);
    chk("rd40_t2_pready", apb.pready, 1);
    chk("rd40_t2_pslverr", apb.pslverr, exp_err);
    chk("rd40_t2_prdata", apb.prdata, 0);

    // back-to-back write then read of 0x004
    setup(1'b1, 12'h004, 32'h1234_5678);
    access(1'b1);
    @(negedge clk);
    chk("b2b_wr_reg_wr", reg_wr, 16'h0002);
    next_cycle();
    @(negedge clk);
    chk("b2b_wr_pready", apb.pready, 1);
    setup(1'b0, 12'h004, 32'h0);
    @(negedge clk);
    chk("b2b_t3_pready", apb.pready, 0);
    access(1'b1);
    @(negedge clk);
    chk("b2b_rd_reg_rd", reg_rd, 16'h0002);
    next_cycle();
    @(negedge clk);
    chk("b2b_t5_prdata", apb.prdata, 32'h1234_5678);
    chk("b2b_t5_pready", apb.pready, 1);

    // abort: psel dropped during STROBE
    setup(1'b1, 12'h014, 32'h0000_00A5);
    access(1'b0);
    @(negedge clk);
    chk("abort_t1_reg_wr", reg_wr, 16'h0020);
    next_cycle();
    @(negedge clk);
    chk("abort_t2_pready", apb.pready, 0);
    chk("abort_field5", field[5], 32'h0000_00A5);

    // async reset mid-STROBE
    setup(1'b1, 12'h008, 32'h1111_1111);
    access(1'b1);
    @(negedge clk);
    chk("rstmid_pre_reg_wr", reg_wr, 16'h0004);
    #1 rst_l = 1'b0;
    #1;
    chk("rstmid_strobes", {reg_rd, reg_wr, acc}, 0);
    chk("rstmid_prdata", apb.prdata, 0);
    chk("rstmid_wdata", sw_wdata, 0);
    chk("rstmid_pready", apb.pready, 0);
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(posedge clk); #1 rst_l = 1'b1;
    @(negedge clk);
    chk("rstmid_after_strobes", {reg_rd, reg_wr, acc}, 0);
    chk("rstmid_after_pready", apb.pready, 0);
    chk("rstmid_field2", field[2], 0);

    setup(1'b1, 12'h010, 32'hCAFE_F00D);
    access(1'b1);
    @(negedge clk);
    chk("post_rst_reg_wr", reg_wr, 16'h0010);
    chk("post_rst_wdata", sw_wdata, 32'hCAFE_F00D);
    next_cycle();
    @(negedge clk);
    chk("post_rst_pready", apb.pready, 1);
    chk("post_rst_field4", field[4], 32'hCAFE_F00D);
    idle_bus();
    @(negedge clk);
    chk("no_rd_wr_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
